// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain stage for the dual-clock FIFO (rclk domain).
// Pops the FIFO against rempty, absorbs the RD_LAT read latency, and buffers
// the popped words in a credit-controlled buffer. The words leave as a
// valid/ready stream, and m_last marks every PKT_LEN-th beat.
// Ports: rclk, rrst (sync, active high), rempty, rdata -> rinc;
//        m_valid/m_ready/m_data/m_last stream; busy.
// Option: define FIFO_RD_STATS_EN to add pop_cnt, stall_cnt and pkt_cnt.
module fifo_rd_stream #(
    parameter int DSIZE     = 16,
    parameter int RD_LAT    = 1,
    parameter int BUF_DEPTH = 3,
    parameter int PKT_LEN   = 4
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [DSIZE-1:0] m_data,
    output logic             m_last,
`ifdef FIFO_RD_STATS_EN
    output logic [31:0]      pop_cnt,
    output logic [31:0]      stall_cnt,
    output logic [15:0]      pkt_cnt,
`endif
    output logic             busy
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CW = 4;
    localparam int BW = $clog2(PKT_LEN) + 1;

    logic [RD_LAT-1:0] pipe_q, pipe_d;
    logic [CW-1:0]     buf_cnt_q, buf_cnt_d;
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [DSIZE-1:0]  buf_mem_q [BUF_DEPTH];
    logic [CW-1:0]     inflight;
    logic              cap;
    logic              pop;
    logic              at_last;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(pipe_q[i]);
        end
    end

    // Credit check uses registered state only, so m_ready never reaches rinc.
    assign rinc = !rempty && !rrst &&
                  ((buf_cnt_q + inflight) < CW'(BUF_DEPTH));

    assign cap     = pipe_q[RD_LAT-1];
    assign m_valid = (buf_cnt_q != '0);
    assign pop     = m_valid && m_ready;
    assign m_data  = m_valid ? buf_mem_q[head_q] : '0;
    assign at_last = (beat_cnt_q == BW'(PKT_LEN - 1));
    assign m_last  = m_valid && at_last;
    assign busy    = (buf_cnt_q != '0) || (inflight != '0);

    always_comb begin
        pipe_d[0] = rinc;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        buf_cnt_d  = buf_cnt_q + CW'(cap) - CW'(pop);
        head_d     = pop ? ptr_inc(head_q) : head_q;
        tail_d     = cap ? ptr_inc(tail_q) : tail_q;
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = at_last ? '0 : beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            pipe_q     <= '0;
            buf_cnt_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            pipe_q     <= pipe_d;
            buf_cnt_q  <= buf_cnt_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Storage needs no reset; m_data is masked while the buffer is empty.
    always_ff @(posedge rclk) begin
        if (cap && !rrst) begin
            buf_mem_q[tail_q] <= rdata;
        end
    end

`ifdef FIFO_RD_STATS_EN
    logic [31:0] pop_cnt_q, pop_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    always_comb begin
        pop_cnt_d   = pop_cnt_q;
        stall_cnt_d = stall_cnt_q;
        pkt_cnt_d   = pkt_cnt_q;
        if (rinc && pop_cnt_q != '1) begin
            pop_cnt_d = pop_cnt_q + 1'b1;
        end
        if (m_valid && !m_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (pop && at_last && pkt_cnt_q != '1) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            pop_cnt_q   <= '0;
            stall_cnt_q <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            pop_cnt_q   <= pop_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    assign pop_cnt   = pop_cnt_q;
    assign stall_cnt = stall_cnt_q;
    assign pkt_cnt   = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed bench for fifo_rd_stream with default parameters.
// Models the FIFO read side (one-cycle registered rdata) as a queue.
module tb_fifo_rd_stream;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        rempty;
    logic [15:0] rdata;
    logic        rinc;
    logic        m_valid;
    logic        m_ready;
    logic [15:0] m_data;
    logic        m_last;
    logic        busy;
`ifdef FIFO_RD_STATS_EN
    logic [31:0] pop_cnt;
    logic [31:0] stall_cnt;
    logic [15:0] pkt_cnt;
`endif

    int total = 0;
    int bad   = 0;

    logic [15:0] fifo_q[$];
    bit          gate;

    fifo_rd_stream dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
`ifdef FIFO_RD_STATS_EN
        .pop_cnt   (pop_cnt),
        .stall_cnt (stall_cnt),
        .pkt_cnt   (pkt_cnt),
`endif
        .busy      (busy)
    );

    always #5 rclk = ~rclk;

    always @(negedge rclk) begin
        if (!rrst) begin
            total++;
            assert (dut.buf_cnt_q <= 4'd3) else begin
                bad++;
                $error("FAIL buf_cnt_bound obs=%0d exp<=3", dut.buf_cnt_q);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        rempty = (fifo_q.size() == 0) || gate;
    endtask

    // Advance one clock; the modelled FIFO presents the popped word
    // one cycle after an accepted rinc.
    task automatic step();
        bit p;
        p = rinc;
        @(posedge rclk);
        #1;
        if (p && fifo_q.size() != 0) rdata = fifo_q.pop_front();
    endtask

    task automatic do_reset(input int n);
        rrst = 1'b1;
        fifo_q.delete();
        gate = 1'b0;
        upd();
        repeat (n) step();
        rrst = 1'b0;
    endtask

    task automatic load(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) fifo_q.push_back(base + 16'(i));
    endtask

    bit          bp_rinc  [18] = '{1,1,1,1,0,0,0,0,0,0,0,1,1,1,1,0,0,0};
    bit          bp_valid [18] = '{0,0,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,0};
    bit          bp_ready [18] = '{1,1,1,0,0,0,0,0,0,0,1,1,1,1,1,1,1,1};
    logic [15:0] bp_data  [18] = '{0,0,1,2,2,2,2,2,2,2,2,3,4,5,6,7,8,0};
    bit          bp_last  [18] = '{0,0,0,0,0,0,0,0,0,0,0,0,1,0,0,0,1,0};

    initial begin
        int idx;
        rrst    = 1'b1;
        rempty  = 1'b1;
        rdata   = '0;
        m_ready = 1'b1;
        gate    = 1'b0;

        // Reset and idle
        do_reset(3);
        #1;
        chk("rst_m_data", m_data, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_beat", dut.beat_cnt_q, 0);
        for (int c = 0; c < 10; c++) begin
            upd();
            #1;
            chk("idle_rinc", rinc, 0);
            chk("idle_valid", m_valid, 0);
            chk("idle_busy", busy, 0);
            step();
        end

        // Streaming 0x0001..0x0008
        do_reset(1);
        load(16'h0001, 8);
        for (int c = 0; c < 12; c++) begin
            m_ready = 1'b1;
            upd();
            #1;
            chk("str_rinc", rinc, 32'(c < 8));
            chk("str_valid", m_valid, 32'(c >= 2 && c < 10));
            chk("str_data", m_data, (c >= 2 && c < 10) ? 32'(c - 1) : 0);
            chk("str_last", m_last, 32'(c == 5 || c == 9));
            step();
        end
        chk("str_beat_end", dut.beat_cnt_q, 0);
        chk("str_busy_end", busy, 0);

        // Backpressure: m_ready low in cycles 3..9
        do_reset(1);
        load(16'h0001, 8);
        for (int c = 0; c < 18; c++) begin
            m_ready = bp_ready[c];
            upd();
            #1;
            chk("bp_rinc", rinc, 32'(bp_rinc[c]));
            chk("bp_valid", m_valid, 32'(bp_valid[c]));
            chk("bp_data", m_data, 32'(bp_data[c]));
            chk("bp_last", m_last, 32'(bp_last[c]));
            step();
        end
`ifdef FIFO_RD_STATS_EN
        chk("st_pop", pop_cnt, 8);
        chk("st_stall", stall_cnt, 7);
        chk("st_pkt", pkt_cnt, 2);
`endif

        // Sparse source: rempty forced high on odd cycles
        do_reset(1);
        load(16'h00A0, 6);
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            m_ready = 1'b1;
            gate = c[0];
            upd();
            #1;
            if (m_valid && m_ready) begin
                chk("sp_data", m_data, 32'(16'h00A0 + 16'(idx)));
                chk("sp_last", m_last, 32'(idx == 3));
                idx++;
            end
            step();
        end
        gate = 1'b0;
        chk("sp_count", idx, 6);
        chk("sp_beat", dut.beat_cnt_q, 2);

        // Mid-operation reset with two buffered and one in flight
        do_reset(1);
        load(16'h0001, 8);
        for (int c = 0; c < 5; c++) begin
            m_ready = bp_ready[c];
            upd();
            #1;
            if (c == 4) begin
                chk("mr_buf_cnt", dut.buf_cnt_q, 2);
                chk("mr_inflight", dut.pipe_q, 1);
                chk("mr_beat_pre", dut.beat_cnt_q, 1);
                rrst = 1'b1;
                fifo_q.delete();
                upd();
                #1;
            end
            step();
        end
        rrst = 1'b0;
        m_ready = 1'b1;
        upd();
        #1;
        chk("mr_valid", m_valid, 0);
        chk("mr_busy", busy, 0);
        chk("mr_beat", dut.beat_cnt_q, 0);
        load(16'h0011, 4);
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            upd();
            #1;
            if (m_valid && m_ready) begin
                chk("mr_data", m_data, 32'(16'h0011 + 16'(idx)));
                chk("mr_last", m_last, 32'(idx == 3));
                idx++;
            end
            step();
        end
        chk("mr_count", idx, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
